// File: rtl/ipg_pkg.sv
// Shared 64b/66b block constants and IPG stuffing field geometry, common to the
// transmit inserter and the receive extractor.
package ipg_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    localparam logic [7:0] BLOCK_TYPE_CTRL     = 8'h1e;
    localparam logic [7:0] BLOCK_TYPE_OS_4     = 8'h2d;
    localparam logic [7:0] BLOCK_TYPE_START_4  = 8'h33;
    localparam logic [7:0] BLOCK_TYPE_OS_START = 8'h66;
    localparam logic [7:0] BLOCK_TYPE_OS_04    = 8'h55;
    localparam logic [7:0] BLOCK_TYPE_START_0  = 8'h78;
    localparam logic [7:0] BLOCK_TYPE_OS_0     = 8'h4b;
    localparam logic [7:0] BLOCK_TYPE_TERM_0   = 8'h87;
    localparam logic [7:0] BLOCK_TYPE_TERM_1   = 8'h99;
    localparam logic [7:0] BLOCK_TYPE_TERM_2   = 8'haa;
    localparam logic [7:0] BLOCK_TYPE_TERM_3   = 8'hb4;
    localparam logic [7:0] BLOCK_TYPE_TERM_4   = 8'hcc;
    localparam logic [7:0] BLOCK_TYPE_TERM_5   = 8'hd2;
    localparam logic [7:0] BLOCK_TYPE_TERM_6   = 8'he1;
    localparam logic [7:0] BLOCK_TYPE_TERM_7   = 8'hff;

    // Stuffable bits per block type; field always ends at its MSB and runs downward.
    localparam logic [5:0] CAP_CTRL    = 6'd56;
    localparam logic [5:0] CAP_OS_4    = 6'd24;
    localparam logic [5:0] CAP_START_4 = 6'd24;
    localparam logic [5:0] CAP_OS_0    = 6'd24;
    localparam logic [5:0] CAP_TERM_0  = 6'd48;
    localparam logic [5:0] CAP_TERM_1  = 6'd40;
    localparam logic [5:0] CAP_TERM_2  = 6'd32;
    localparam logic [5:0] CAP_TERM_3  = 6'd24;
    localparam logic [5:0] CAP_TERM_4  = 6'd16;
    localparam logic [5:0] CAP_TERM_5  = 6'd8;
    localparam logic [5:0] CAP_NONE    = 6'd0;

    localparam logic [5:0] MSB_UPPER = 6'd63;
    localparam logic [5:0] MSB_LOWER = 6'd31;

endpackage

// File: rtl/ipg_rx_field_lut.sv
// Block type to stuffing field lookup: capacity and field MSB bit position.
// Combinational, zero latency; no flow control.
module ipg_rx_field_lut
    import ipg_pkg::*;
(
    input  logic [7:0] block_type,
    output logic [5:0] cap,
    output logic [5:0] field_msb
);

    always_comb begin
        cap       = CAP_NONE;
        field_msb = MSB_UPPER;
        case (block_type)
            BLOCK_TYPE_CTRL:    cap = CAP_CTRL;
            BLOCK_TYPE_OS_4: begin
                cap       = CAP_OS_4;
                field_msb = MSB_LOWER;
            end
            BLOCK_TYPE_START_4: begin
                cap       = CAP_START_4;
                field_msb = MSB_LOWER;
            end
            BLOCK_TYPE_OS_0:    cap = CAP_OS_0;
            BLOCK_TYPE_TERM_0:  cap = CAP_TERM_0;
            BLOCK_TYPE_TERM_1:  cap = CAP_TERM_1;
            BLOCK_TYPE_TERM_2:  cap = CAP_TERM_2;
            BLOCK_TYPE_TERM_3:  cap = CAP_TERM_3;
            BLOCK_TYPE_TERM_4:  cap = CAP_TERM_4;
            BLOCK_TYPE_TERM_5:  cap = CAP_TERM_5;
            default:            cap = CAP_NONE;
        endcase
    end

endmodule

// File: rtl/ipg_rx_extract.sv
// Extracts IPG-stuffed message bits from received control blocks and reassembles them.
// Forward path 1 cycle, message valid 1 cycle after final chunk; forward stream never stalls,
// a completed message is dropped if the previous one is still unaccepted. IPG_RX_RESTORE_EN clears consumed bits.
module ipg_rx_extract
    import ipg_pkg::*;
#(
    parameter int MSG_WIDTH   = 520,
    parameter int COUNT_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [63:0]            encoded_rx_data,
    input  logic [1:0]             encoded_rx_hdr,
    input  logic                   encoded_rx_valid,
    input  logic                   rx_block_lock,
    input  logic                   ipg_en,
    output logic [63:0]            out_rx_data,
    output logic [1:0]             out_rx_hdr,
    output logic                   out_rx_valid,
    output logic [MSG_WIDTH-1:0]   rx_ipg_data,
    output logic                   rx_ipg_valid,
    input  logic                   rx_ipg_ready,
    output logic                   rx_ipg_drop,
    output logic [COUNT_WIDTH-1:0] rx_ipg_count
);

    localparam logic [COUNT_WIDTH-1:0] MSG_LEN = COUNT_WIDTH'(MSG_WIDTH);

    logic [5:0]             cap;
    logic [5:0]             field_msb;
    logic                   eligible;
    logic                   final_chunk;
    logic                   complete;
    logic                   out_free;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] remaining;
    logic [6:0]             take;
    logic [63:0]            take_mask;
    logic [63:0]            chunk;
    logic [63:0]            fwd_data;
    logic [MSG_WIDTH-1:0]   placed;
    logic [MSG_WIDTH-1:0]   assembled;
    logic [MSG_WIDTH-1:0]   asm_q;
    logic [MSG_WIDTH-1:0]   msg_q;
    logic                   msg_vld_q;
    logic                   drop_q;

    ipg_rx_field_lut u_field_lut (
        .block_type (encoded_rx_data[7:0]),
        .cap        (cap),
        .field_msb  (field_msb)
    );

    assign eligible    = encoded_rx_valid && (encoded_rx_hdr == SYNC_CTRL) && ipg_en && rx_block_lock;
    assign remaining   = MSG_LEN - count_q;
    assign final_chunk = (cap != CAP_NONE) && (COUNT_WIDTH'(cap) >= remaining);
    assign take        = final_chunk ? 7'(remaining) : {1'b0, cap};
    assign take_mask   = ~(64'hFFFF_FFFF_FFFF_FFFF >> take);

    // Left-align the field so its MSB sits at bit 63, keep only the bits taken,
    // then drop them into the message starting at bit MSG_WIDTH-1-count.
    assign chunk     = (encoded_rx_data << (MSB_UPPER - field_msb)) & take_mask;
    assign placed    = {chunk, {(MSG_WIDTH-64){1'b0}}} >> count_q;
    assign assembled = asm_q | placed;

    assign complete = eligible && final_chunk;
    assign out_free = !msg_vld_q || rx_ipg_ready;

`ifdef IPG_RX_RESTORE_EN
    logic [63:0] consumed;
    assign consumed = take_mask >> (MSB_UPPER - field_msb);
    assign fwd_data = eligible ? (encoded_rx_data & ~consumed) : encoded_rx_data;
`else
    assign fwd_data = encoded_rx_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_rx_data  <= '0;
            out_rx_hdr   <= '0;
            out_rx_valid <= 1'b0;
        end else begin
            out_rx_data  <= fwd_data;
            out_rx_hdr   <= encoded_rx_hdr;
            out_rx_valid <= encoded_rx_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            asm_q   <= '0;
        end else if (!rx_block_lock || !ipg_en) begin
            count_q <= '0;
            asm_q   <= '0;
        end else if (eligible) begin
            if (final_chunk) begin
                count_q <= '0;
                asm_q   <= '0;
            end else begin
                count_q <= count_q + COUNT_WIDTH'(cap);
                asm_q   <= assembled;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_q     <= '0;
            msg_vld_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            drop_q <= complete && !out_free;
            if (complete && out_free) begin
                msg_q     <= assembled;
                msg_vld_q <= 1'b1;
            end else if (rx_ipg_ready) begin
                msg_vld_q <= 1'b0;
            end
        end
    end

    assign rx_ipg_data  = msg_q;
    assign rx_ipg_valid = msg_vld_q;
    assign rx_ipg_drop  = drop_q;
    assign rx_ipg_count = count_q;

endmodule

// File: tb/tb_ipg_rx_extract.sv
// Directed bench for ipg_rx_extract: a transmit-side stuffing model builds blocks from known
// 520-bit patterns; reassembly, handshake, drop, lock loss, reset and forwarding are checked.
module tb_ipg_rx_extract;

    localparam int MSG = 520;

    logic            clk;
    logic            rst_n;
    logic [63:0]     encoded_rx_data;
    logic [1:0]      encoded_rx_hdr;
    logic            encoded_rx_valid;
    logic            rx_block_lock;
    logic            ipg_en;
    logic [63:0]     out_rx_data;
    logic [1:0]      out_rx_hdr;
    logic            out_rx_valid;
    logic [MSG-1:0]  rx_ipg_data;
    logic            rx_ipg_valid;
    logic            rx_ipg_ready;
    logic            rx_ipg_drop;
    logic [9:0]      rx_ipg_count;

    int              checks;
    int              failures;
    int              tx_cnt;
    logic [MSG-1:0]  cur_pat;
    logic [MSG-1:0]  pat_a, pat_b, pat_c, pat_d;
    logic [63:0]     filler;
    logic [63:0]     fwd_exp;
    logic [7:0]      mix_types [4];
    int              k;

    ipg_rx_extract u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .encoded_rx_data  (encoded_rx_data),
        .encoded_rx_hdr   (encoded_rx_hdr),
        .encoded_rx_valid (encoded_rx_valid),
        .rx_block_lock    (rx_block_lock),
        .ipg_en           (ipg_en),
        .out_rx_data      (out_rx_data),
        .out_rx_hdr       (out_rx_hdr),
        .out_rx_valid     (out_rx_valid),
        .rx_ipg_data      (rx_ipg_data),
        .rx_ipg_valid     (rx_ipg_valid),
        .rx_ipg_ready     (rx_ipg_ready),
        .rx_ipg_drop      (rx_ipg_drop),
        .rx_ipg_count     (rx_ipg_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [MSG-1:0] obs, input logic [MSG-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MSG-1:0] mkpat(input logic [31:0] seed);
        logic [543:0] w;
        for (int i = 0; i < 17; i++)
            w[i*32 +: 32] = seed ^ (32'h9E37_79B9 * 32'(i + 1));
        return w[MSG-1:0];
    endfunction

    function automatic int tb_cap(input logic [7:0] t);
        case (t)
            8'h1e: return 56;
            8'h2d, 8'h33, 8'h4b, 8'hb4: return 24;
            8'h87: return 48;
            8'h99: return 40;
            8'haa: return 32;
            8'hcc: return 16;
            8'hd2: return 8;
            default: return 0;
        endcase
    endfunction

    function automatic int tb_msb(input logic [7:0] t);
        return (t == 8'h2d || t == 8'h33) ? 31 : 63;
    endfunction

    task automatic send_raw(input logic [63:0] d, input logic [1:0] hdr, input logic vld);
        encoded_rx_data  = d;
        encoded_rx_hdr   = hdr;
        encoded_rx_valid = vld;
        @(posedge clk);
        #1;
    endtask

    // Transmit-side model: fills the field MSB-first from cur_pat, leaves filler elsewhere.
    task automatic send_model(input logic [7:0] t, input logic [1:0] hdr, input logic vld);
        logic [63:0] d;
        int cap, msb;
        bit elig;
        d   = {filler[63:8], t};
        cap = tb_cap(t);
        msb = tb_msb(t);
        for (int i = 0; i < cap; i++)
            if (tx_cnt + i < MSG) d[msb-i] = cur_pat[MSG-1-tx_cnt-i];
        elig = vld && (hdr == 2'b01) && ipg_en && rx_block_lock;
        send_raw(d, hdr, vld);
        if (elig && cap > 0) begin
            tx_cnt += cap;
            if (tx_cnt >= MSG) tx_cnt = 0;
        end
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        tx_cnt           = 0;
        filler           = 64'h5AC3_96E1_0F3C_A55A;
        pat_a            = mkpat(32'hC3A5_1F0E);
        pat_b            = mkpat(32'h1234_ABCD);
        pat_c            = mkpat(32'h0F0F_7777);
        pat_d            = mkpat(32'hDEAD_BEEF);
        mix_types[0]     = 8'h55;
        mix_types[1]     = 8'hcc;
        mix_types[2]     = 8'h87;
        mix_types[3]     = 8'h2d;
        rst_n            = 1'b0;
        encoded_rx_data  = '0;
        encoded_rx_hdr   = 2'b00;
        encoded_rx_valid = 1'b0;
        rx_block_lock    = 1'b1;
        ipg_en           = 1'b1;
        rx_ipg_ready     = 1'b0;

        #7;
        chk("rst_out_data", MSG'(out_rx_data), '0);
        chk("rst_out_hdr", MSG'(out_rx_hdr), '0);
        chk("rst_out_valid", MSG'(out_rx_valid), '0);
        chk("rst_ipg_data", rx_ipg_data, '0);
        chk("rst_ipg_valid", MSG'(rx_ipg_valid), '0);
        chk("rst_ipg_drop", MSG'(rx_ipg_drop), '0);
        chk("rst_ipg_count", MSG'(rx_ipg_count), '0);
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Continuous CTRL blocks.
        cur_pat = pat_a;
        send_model(8'h1e, 2'b01, 1'b1);
        chk("ctrl_count_1", MSG'(rx_ipg_count), MSG'(56));
        for (int i = 1; i < 9; i++) send_model(8'h1e, 2'b01, 1'b1);
        chk("ctrl_count_9", MSG'(rx_ipg_count), MSG'(504));
        chk("ctrl_not_yet_valid", MSG'(rx_ipg_valid), '0);
        send_model(8'h1e, 2'b01, 1'b1);
        chk("ctrl_count_wrap", MSG'(rx_ipg_count), '0);
        chk("ctrl_valid", MSG'(rx_ipg_valid), MSG'(1));
        chk("ctrl_data", rx_ipg_data, pat_a);
        send_raw('0, 2'b00, 1'b0);
        chk("ctrl_valid_held", MSG'(rx_ipg_valid), MSG'(1));
        rx_ipg_ready = 1'b1;
        send_raw('0, 2'b00, 1'b0);
        chk("ctrl_valid_clear", MSG'(rx_ipg_valid), '0);
        rx_ipg_ready = 1'b0;

        // Mixed block types with non-advancing blocks in between.
        cur_pat = pat_b;
        send_model(8'h55, 2'b01, 1'b1);
        chk("mix_55", MSG'(rx_ipg_count), '0);
        send_model(8'hcc, 2'b01, 1'b1);
        chk("mix_cc", MSG'(rx_ipg_count), MSG'(16));
        send_model(8'h1e, 2'b10, 1'b1);
        chk("mix_datablk", MSG'(rx_ipg_count), MSG'(16));
        send_model(8'h1e, 2'b00, 1'b1);
        chk("mix_hdr00", MSG'(rx_ipg_count), MSG'(16));
        send_model(8'h1e, 2'b01, 1'b0);
        chk("mix_novalid", MSG'(rx_ipg_count), MSG'(16));
        send_model(8'h87, 2'b01, 1'b1);
        chk("mix_87", MSG'(rx_ipg_count), MSG'(64));
        send_model(8'h2d, 2'b01, 1'b1);
        chk("mix_2d", MSG'(rx_ipg_count), MSG'(88));
        k = 0;
        while (tx_cnt != 0 && k < 40) begin
            send_model(mix_types[k % 4], 2'b01, 1'b1);
            k++;
        end
        chk("mix_valid", MSG'(rx_ipg_valid), MSG'(1));
        chk("mix_data", rx_ipg_data, pat_b);

        // Second message completes while the first is held: dropped.
        cur_pat = pat_c;
        for (int i = 0; i < 10; i++) send_model(8'h1e, 2'b01, 1'b1);
        chk("drop_pulse", MSG'(rx_ipg_drop), MSG'(1));
        chk("drop_valid_held", MSG'(rx_ipg_valid), MSG'(1));
        chk("drop_data_kept", rx_ipg_data, pat_b);
        send_raw('0, 2'b00, 1'b0);
        chk("drop_one_cycle", MSG'(rx_ipg_drop), '0);
        rx_ipg_ready = 1'b1;
        send_raw('0, 2'b00, 1'b0);
        chk("drop_ready_clear", MSG'(rx_ipg_valid), '0);
        rx_ipg_ready = 1'b0;

        // Lock loss part way through.
        cur_pat = pat_d;
        for (int i = 0; i < 5; i++) send_model(8'h1e, 2'b01, 1'b1);
        chk("lock_count_280", MSG'(rx_ipg_count), MSG'(280));
        rx_block_lock = 1'b0;
        send_model(8'h1e, 2'b01, 1'b1);
        chk("lock_count_clear", MSG'(rx_ipg_count), '0);
        rx_block_lock = 1'b1;
        tx_cnt        = 0;
        for (int i = 0; i < 10; i++) send_model(8'h1e, 2'b01, 1'b1);
        chk("lock_valid", MSG'(rx_ipg_valid), MSG'(1));
        chk("lock_data", rx_ipg_data, pat_d);

        // Asynchronous reset mid-message.
        cur_pat = pat_a;
        for (int i = 0; i < 3; i++) send_model(8'h1e, 2'b01, 1'b1);
        chk("rst_pre_count", MSG'(rx_ipg_count), MSG'(168));
        rst_n = 1'b0;
        #2;
        chk("arst_count", MSG'(rx_ipg_count), '0);
        chk("arst_valid", MSG'(rx_ipg_valid), '0);
        chk("arst_data", rx_ipg_data, '0);
        chk("arst_out_valid", MSG'(out_rx_valid), '0);
        chk("arst_out_data", MSG'(out_rx_data), '0);
        #2;
        rst_n  = 1'b1;
        tx_cnt = 0;
        send_model(8'h1e, 2'b01, 1'b1);
        chk("post_rst_count", MSG'(rx_ipg_count), MSG'(56));

        // Forwarding of an eligible CTRL block.
`ifdef IPG_RX_RESTORE_EN
        fwd_exp = 64'h0000_0000_0000_001e;
`else
        fwd_exp = 64'hABAB_ABAB_ABAB_AB1e;
`endif
        send_raw(64'hABAB_ABAB_ABAB_AB1e, 2'b01, 1'b1);
        chk("fwd_ctrl_data", MSG'(out_rx_data), MSG'(fwd_exp));
        chk("fwd_ctrl_hdr", MSG'(out_rx_hdr), MSG'(2'b01));
        chk("fwd_ctrl_valid", MSG'(out_rx_valid), MSG'(1));
        ipg_en = 1'b0;
        send_raw(64'hABAB_ABAB_ABAB_ABcc, 2'b01, 1'b1);
        chk("fwd_disabled_data", MSG'(out_rx_data), MSG'(64'hABAB_ABAB_ABAB_ABcc));
        chk("en_off_count", MSG'(rx_ipg_count), '0);
        ipg_en = 1'b1;
        send_raw(64'h0123_4567_89AB_CD1e, 2'b10, 1'b1);
        chk("fwd_data_blk", MSG'(out_rx_data), MSG'(64'h0123_4567_89AB_CD1e));
        chk("fwd_data_hdr", MSG'(out_rx_hdr), MSG'(2'b10));
        send_raw('0, 2'b00, 1'b0);
        chk("fwd_idle_valid", MSG'(out_rx_valid), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ipg_rx_extract.md
# ipg_rx_extract

Receive-side counterpart of the IPG transmit inserter: sits between the 64b/66b receive gearbox/descrambler and the XGMII decoder. It extracts the message bits the far-end transmitter stuffed into idle control-field space of 66-bit control blocks and reassembles them into a 520-bit message. It forwards each encoded block one cycle later, optionally with the stuffed field cleared back to idle.

## Interface
- MSG_WIDTH, 520, message length in bits; must equal the transmitter's message length.
- COUNT_WIDTH, 10, width of the received-bit counter; must satisfy 2^COUNT_WIDTH > MSG_WIDTH.
- clk  in  1  receive clock.
- rst_n  in  1  reset; asynchronous, active-low.
- encoded_rx_data  in  64  descrambled block payload; bits [7:0] hold the block type.
- encoded_rx_hdr  in  2  sync header; 2'b10 marks a data block, 2'b01 marks a control block.
- encoded_rx_valid  in  1  block qualifier.
- rx_block_lock  in  1  block lock from the frame synchroniser.
- ipg_en  in  1  enables extraction.
- out_rx_data  out  64  forwarded block.
- out_rx_hdr  out  2  forwarded header.
- out_rx_valid  out  1  forwarded qualifier.
- rx_ipg_data  out  MSG_WIDTH  assembled message.
- rx_ipg_valid  out  1  message available.
- rx_ipg_ready  in  1  sink accepts the message.
- rx_ipg_drop  out  1  one-cycle pulse; a completed message was discarded.
- rx_ipg_count  out  COUNT_WIDTH  bits received so far for the current message (debug).

## Operation
- A block is eligible when encoded_rx_valid=1, encoded_rx_hdr=01, ipg_en=1 and rx_block_lock=1.
- Field per block type (capacity, field bits):
  - 1e CTRL: 56, [63:8].
  - 2d OS_4: 24, [31:8].
  - 33 START_4: 24, [31:8].
  - 4b OS_0: 24, [63:40].
  - 87 TERM_0: 48, [63:16].
  - 99 TERM_1: 40, [63:24].
  - aa TERM_2: 32, [63:32].
  - b4 TERM_3: 24, [63:40].
  - cc TERM_4: 16, [63:48].
  - d2 TERM_5: 8, [63:56].
  - All other types (78, 55, 66, e1, ff): capacity 0, no extraction.
- Let remaining = MSG_WIDTH − count.
- Capacity < remaining: take all capacity bits of the field; they become the next message bits, MSB first (message bit MSG_WIDTH−1−count downward). Then count += capacity.
- Capacity ≥ remaining (final chunk): take only the top `remaining` bits of the field (field MSB downward). The message completes and count returns to 0. Lower field bits are ignored.
- Completion when rx_ipg_valid=0 or rx_ipg_ready=1 (output free): load rx_ipg_data and set rx_ipg_valid.
- Completion when rx_ipg_valid=1 and rx_ipg_ready=0: discard the new message, pulse rx_ipg_drop, keep the old message held.
- Handshake: rx_ipg_valid stays high with rx_ipg_data stable until a cycle with rx_ipg_ready=1. It clears on that cycle unless a new completion reloads it in the same cycle.
- rx_block_lock=0 or ipg_en=0: count clears to 0 and any partial message is discarded. A held rx_ipg_valid message is kept.
- Header-invalid blocks (00/11), data blocks, and cycles with encoded_rx_valid=0 do not advance count.

## Timing
- Forward path latency is exactly 1 cycle: out_* are registered copies of the inputs, modified per Configuration.
- rx_ipg_valid rises in the cycle after the final-chunk block is sampled.
- Reset values: out_rx_data=0, out_rx_hdr=0, out_rx_valid=0, rx_ipg_data=0, rx_ipg_valid=0, rx_ipg_drop=0, rx_ipg_count=0.
- Asserting rst_n low mid-message clears everything immediately, with no completion.
- Throughput: one block per cycle, with no stall path on the forwarded stream.

## Configuration
- IPG_RX_RESTORE_EN defined: for each eligible block, zero every field bit that was consumed in out_rx_data (idle /I/ = 7'h00 code). Bits [7:0] and unconsumed bits are untouched.
- IPG_RX_RESTORE_EN undefined: out_rx_data equals the input unchanged.

## Structure
- Shared package ipg_pkg holds:
  - the SYNC_DATA/SYNC_CTRL constants;
  - the BLOCK_TYPE_* constants;
  - the per-type capacity and field-MSB constants, shared with the transmit inserter.
- Sub-module ipg_rx_field_lut: combinational, block type → {capacity[5:0], field_msb[5:0]}.
- The top level holds the counter, the assembly register, the output holding register and the forward pipeline.

## Test plan
- Continuous 1e blocks, lock=1, ipg_en=1, known 520-bit pattern stuffed MSB-first:
  - nine blocks give count=504;
  - the tenth block contributes its top 16 bits;
  - rx_ipg_valid rises one cycle later with rx_ipg_data equal to the pattern.
- Mixed cc/87/2d/55 sequence: 55 does not advance count, cc adds 16, 87 adds 48, 2d adds 24 from [31:8]. The assembled message matches the transmitter model bit-exactly.
- rx_ipg_ready=0 while a second message completes: rx_ipg_drop pulses for one cycle and the first message stays held. Raising ready afterwards clears valid.
- rx_block_lock dropped at count=280: count goes to 0. The next message reassembles from bit 519.
- rst_n low mid-message: all outputs go to 0 asynchronously. After release, the first 1e block yields count=56.
- With IPG_RX_RESTORE_EN, a 1e block carrying 0xAB..AB1e forwards 0x00000000_0000001e. Without the macro it forwards unchanged, one cycle later.
